// File: rtl/ofdm_pkg.sv
// Shared 802.11a interleaver definitions: mode encodings and per-mode permutation constants.
package ofdm_pkg;

  localparam int unsigned NCBPS_MAX = 288;
  localparam int unsigned CNT_W     = 9;

  localparam logic [1:0] MODE_BPSK  = 2'd0;
  localparam logic [1:0] MODE_QPSK  = 2'd1;
  localparam logic [1:0] MODE_16QAM = 2'd2;
  localparam logic [1:0] MODE_64QAM = 2'd3;

  function automatic logic [CNT_W-1:0] ncbps(input logic [1:0] mode);
    case (mode)
      MODE_BPSK:  return CNT_W'(48);
      MODE_QPSK:  return CNT_W'(96);
      MODE_16QAM: return CNT_W'(192);
      default:    return CNT_W'(288);
    endcase
  endfunction

  function automatic logic [1:0] s(input logic [1:0] mode);
    case (mode)
      MODE_16QAM: return 2'd2;
      MODE_64QAM: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

  function automatic logic [4:0] ncbps16(input logic [1:0] mode);
    case (mode)
      MODE_BPSK:  return 5'd3;
      MODE_QPSK:  return 5'd6;
      MODE_16QAM: return 5'd12;
      default:    return 5'd18;
    endcase
  endfunction

  function automatic logic [1:0] mod3(input logic [3:0] x);
    return 2'(x % 4'd3);
  endfunction

endpackage

// File: rtl/ofdm_interleaver_if.sv
// Serial bit-stream bus between encoder side, interleaver and mapper side.
interface ofdm_interleaver_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic [1:0] out_mode;
  logic       out_sos;
  logic       out_eos;

  modport master (
    output in_valid, in_bit, in_mode, out_ready,
    input  in_ready, out_valid, out_bit, out_mode, out_sos, out_eos
  );

  modport slave (
    input  in_valid, in_bit, in_mode, out_ready,
    output in_ready, out_valid, out_bit, out_mode, out_sos, out_eos
  );
endinterface

// File: rtl/interleaver_addr_gen.sv
// Incremental 802.11a permutation address generator: walks k and yields the permuted index j.
module interleaver_addr_gen
  import ofdm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  input  logic [1:0]       mode,
  output logic [CNT_W-1:0] j,
  output logic             first_k,
  output logic             last_k
);

  logic [3:0]       k_mod;
  logic [4:0]       k_div;
  logic [CNT_W-1:0] i_q;
  logic [1:0]       r_q;
  logic [1:0]       s_m;
  logic [1:0]       k_mod_s;
  logic [1:0]       r_inc;
  logic [4:0]       n16;
  logic [2:0]       t;

  // i mod s equals k_div mod s because Ncbps16 is a multiple of s; r_q tracks it per row.
  always_comb begin
    s_m = s(mode);
    n16 = ncbps16(mode);
    case (s_m)
      2'd2:    k_mod_s = {1'b0, k_mod[0]};
      2'd3:    k_mod_s = mod3(k_mod);
      default: k_mod_s = 2'd0;
    endcase
    t = 3'(r_q) + 3'(s_m) - 3'(k_mod_s);
    if (t >= 3'(s_m)) t = t - 3'(s_m);
    j = i_q - CNT_W'(r_q) + CNT_W'(t);
    r_inc = r_q + 2'd1;
    if (r_inc >= s_m) r_inc = 2'd0;
    first_k = (k_mod == 4'd0) && (k_div == 5'd0);
    last_k  = (k_mod == 4'd15) && (k_div == n16 - 5'd1);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      k_mod <= 4'd0;
      k_div <= 5'd0;
      i_q   <= '0;
      r_q   <= 2'd0;
    end else if (step) begin
      if (last_k) begin
        k_mod <= 4'd0;
        k_div <= 5'd0;
        i_q   <= '0;
        r_q   <= 2'd0;
      end else if (k_mod == 4'd15) begin
        k_mod <= 4'd0;
        k_div <= k_div + 5'd1;
        i_q   <= CNT_W'(k_div + 5'd1);
        r_q   <= r_inc;
      end else begin
        k_mod <= k_mod + 4'd1;
        i_q   <= i_q + CNT_W'(n16);
      end
    end
  end

endmodule

// File: rtl/ofdm_interleaver.sv
// 802.11a transmit block interleaver: ping-pong symbol banks written in permuted order, read sequentially.
module ofdm_interleaver
  import ofdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  ofdm_interleaver_if.slave bus
);

  logic [NCBPS_MAX-1:0] bank [2];
  logic [1:0]           bank_mode [2];
  logic [1:0]           full;
  logic                 wsel;
  logic                 rsel;
  logic [CNT_W-1:0]     rd_j;
  logic [CNT_W-1:0]     wr_j;
  logic                 first_k;
  logic                 last_k;
  logic [1:0]           wr_mode;
  logic [1:0]           rd_mode;
  logic                 in_rdy;
  logic                 out_vld;
  logic                 wr_en;
  logic                 rd_en;
  logic                 rd_last;
  logic                 wr_done;
  logic                 rd_done;

  // Mode is taken live on k=0 and from the bank's latched copy for the rest of the symbol.
  always_comb begin
    in_rdy  = !full[wsel];
    out_vld = full[rsel];
    wr_en   = bus.in_valid && in_rdy;
    rd_en   = out_vld && bus.out_ready;
    wr_mode = first_k ? bus.in_mode : bank_mode[wsel];
    rd_mode = bank_mode[rsel];
    rd_last = (rd_j == ncbps(rd_mode) - CNT_W'(1));
    wr_done = wr_en && last_k;
    rd_done = rd_en && rd_last;
  end

  interleaver_addr_gen u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (1'b0),
    .step    (wr_en),
    .mode    (wr_mode),
    .j       (wr_j),
    .first_k (first_k),
    .last_k  (last_k)
  );

  always_ff @(posedge clk) begin
    if (wr_en) bank[wsel][wr_j] <= bus.in_bit;
  end

  // Write and read completions touch different banks, so both may land in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      full         <= 2'b00;
      wsel         <= 1'b0;
      rsel         <= 1'b0;
      rd_j         <= '0;
      bank_mode[0] <= 2'd0;
      bank_mode[1] <= 2'd0;
    end else begin
      if (wr_en && first_k) bank_mode[wsel] <= bus.in_mode;
      if (wr_done) begin
        full[wsel] <= 1'b1;
        wsel       <= !wsel;
      end
      if (rd_done) begin
        full[rsel] <= 1'b0;
        rsel       <= !rsel;
        rd_j       <= '0;
      end else if (rd_en) begin
        rd_j <= rd_j + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_bit   = out_vld & bank[rsel][rd_j];
  assign bus.out_mode  = out_vld ? rd_mode : 2'd0;
  assign bus.out_sos   = out_vld && (rd_j == '0);
  assign bus.out_eos   = out_vld && rd_last;

endmodule
